// File: rtl/btn_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_queue
//  Description : Synchronises and debounces raw fire buttons, turns each
//                accepted level change into a press/release event, and queues
//                the events in a small first-word fall-through FIFO with a
//                valid/ready handshake. Also exports the debounced levels.
//  Options     : BTN_RELEASE_EVT_EN - when defined, release events are queued
//                as well; when undefined only presses are queued and
//                evt_press is tied high.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_event_queue #(
    parameter int NUM_BTN         = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               flush,
    input  logic               ovf_clr,
    output logic [NUM_BTN-1:0] btn_stable,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [2:0]         evt_btn,
    output logic               evt_press,
    output logic               evt_overflow
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_RELEASE_EVT_EN
    // Event word is {button index, press flag}
    localparam int c_DW = 4;
`else
    // Event word is the button index only; every queued event is a press
    localparam int c_DW = 3;
`endif

    // ------------------------------------------------------------------
    // Signal declarations
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] stable_q, stable_d;
    logic [NUM_BTN-1:0] stable_dly_q, stable_dly_d;
    logic [NUM_BTN-1:0] stable_tgl;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] pend_press_q, pend_press_d;
    logic [NUM_BTN-1:0] pend_any;
    logic [NUM_BTN-1:0] clr_mask;
`ifdef BTN_RELEASE_EVT_EN
    logic [NUM_BTN-1:0] fall;
    logic [NUM_BTN-1:0] pend_rel_q, pend_rel_d;
    logic               sel_press;
`endif
    logic               sel_found;
    logic [2:0]         sel_idx;
    logic               ovf_q, ovf_d;
    logic               ovf_hit;

    logic [c_AW:0]      wr_ptr_q, wr_ptr_d;
    logic [c_AW:0]      rd_ptr_q, rd_ptr_d;
    logic [c_DW-1:0]    mem_q [FIFO_DEPTH];
    logic [c_DW-1:0]    head_q, head_d;
    logic [c_DW-1:0]    wr_data;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    // Two-flop chain per button; sync2_q is the synchronised level
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
        logic [c_CNT_W-1:0] cnt_q, cnt_d;
        logic               tgl;

        // Count consecutive cycles the synchronised level disagrees with the
        // accepted level; any agreement restarts the count from zero
        always_comb begin
            cnt_d = '0;
            tgl   = 1'b0;
            if (sync2_q[gi] != stable_q[gi]) begin
                if (cnt_q == c_CNT_MAX) begin
                    tgl = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
        end

        assign stable_tgl[gi] = tgl;

        // Per-button debounce counter
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Accepted level flips when the counter expires; keep a delayed copy for
    // edge detection one cycle later
    always_comb begin
        stable_d     = stable_q ^ stable_tgl;
        stable_dly_d = stable_q;
    end

    assign rise = stable_q & ~stable_dly_q;
`ifdef BTN_RELEASE_EVT_EN
    assign fall = ~stable_q & stable_dly_q;
`endif

    // ------------------------------------------------------------------
    // Pending-event scanner
    // ------------------------------------------------------------------
`ifdef BTN_RELEASE_EVT_EN
    assign pend_any = pend_press_q | pend_rel_q;
`else
    assign pend_any = pend_press_q;
`endif

    // Pick the lowest-index button with anything pending; a press goes
    // ahead of a release on the same button
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
`ifdef BTN_RELEASE_EVT_EN
        sel_press = 1'b0;
`endif
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend_any[i]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
`ifdef BTN_RELEASE_EVT_EN
                sel_press = pend_press_q[i];
`endif
            end
        end
    end

    // One-hot of the button whose pending bit is consumed this cycle
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            clr_mask[i] = push && (sel_idx == 3'(i));
        end
    end

    // Pending bits: a new edge sets the bit even if it is being consumed on
    // the same cycle, so that edge is not lost; flush drops everything
    always_comb begin
`ifdef BTN_RELEASE_EVT_EN
        pend_press_d = (pend_press_q & ~(clr_mask & {NUM_BTN{sel_press}})) | rise;
        pend_rel_d   = (pend_rel_q & ~(clr_mask & {NUM_BTN{~sel_press}})) | fall;
        if (flush) begin
            pend_press_d = '0;
            pend_rel_d   = '0;
        end
`else
        pend_press_d = (pend_press_q & ~clr_mask) | rise;
        if (flush) begin
            pend_press_d = '0;
        end
`endif
    end

    // Sticky overflow: an edge arriving while the same pending bit is still
    // set is lost; a new loss beats a simultaneous clear
    always_comb begin
        ovf_hit = |(rise & pend_press_q);
`ifdef BTN_RELEASE_EVT_EN
        ovf_hit = ovf_hit | (|(fall & pend_rel_q));
`endif
        if (ovf_hit) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                        (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    assign push       = sel_found && !fifo_full && !flush;
    assign pop        = !fifo_empty && evt_ready && !flush;

`ifdef BTN_RELEASE_EVT_EN
    assign wr_data = {sel_idx, sel_press};
`else
    assign wr_data = sel_idx;
`endif

    // Pointer update and head register; the head register only changes when
    // the FIFO will be non-empty, so the outputs hold while evt_valid is low
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (c_AW + 1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (c_AW + 1)'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        head_d = head_q;
        if (wr_ptr_d != rd_ptr_d) begin
            // The next head may be the entry being written right now
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                head_d = wr_data;
            end else begin
                head_d = mem_q[rd_ptr_d[c_AW-1:0]];
            end
        end
    end

    // Event storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // All control state with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            pend_press_q <= '0;
`ifdef BTN_RELEASE_EVT_EN
            pend_rel_q   <= '0;
`endif
            ovf_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_q       <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            pend_press_q <= pend_press_d;
`ifdef BTN_RELEASE_EVT_EN
            pend_rel_q   <= pend_rel_d;
`endif
            ovf_q        <= ovf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            head_q       <= head_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign btn_stable   = stable_q;
    assign evt_valid    = !fifo_empty;
    assign evt_overflow = ovf_q;
`ifdef BTN_RELEASE_EVT_EN
    assign evt_btn      = head_q[3:1];
    assign evt_press    = head_q[0];
`else
    assign evt_btn      = head_q;
    assign evt_press    = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_event_queue
//  Description : Self-checking bench for btn_event_queue: directed scenarios
//                followed by randomised button/handshake activity, all
//                compared against an event-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_queue;

    localparam int NB = 8;
    localparam int DC = 4;
    localparam int FD = 4;
`ifdef BTN_RELEASE_EVT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic [NB-1:0] btn_raw   = '0;
    logic          flush     = 1'b0;
    logic          ovf_clr   = 1'b0;
    logic          evt_ready = 1'b0;
    logic [NB-1:0] btn_stable;
    logic          evt_valid;
    logic [2:0]    evt_btn;
    logic          evt_press;
    logic          evt_overflow;

    btn_event_queue #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DC),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .flush       (flush),
        .ovf_clr     (ovf_clr),
        .btn_stable  (btn_stable),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_btn     (evt_btn),
        .evt_press   (evt_press),
        .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] b;
        logic       p;
    } ev_t;

    int  n_assert = 0;
    int  n_fail   = 0;

    // Reference model state
    bit  m_s1[NB];
    bit  m_s[NB];
    bit  m_stable[NB];
    bit  m_prev[NB];
    bit  m_pp[NB];
    bit  m_pr[NB];
    int  m_cnt[NB];
    ev_t m_q[$];
    ev_t m_head;
    bit  m_ovf;

    // Events actually handed over by the DUT
    ev_t obs_q[$];
    ev_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_s1[i] = 0; m_s[i] = 0; m_stable[i] = 0; m_prev[i] = 0;
            m_pp[i] = 0; m_pr[i] = 0; m_cnt[i] = 0;
        end
        m_q.delete();
        m_head = '0;
        m_ovf  = 0;
    endtask

    function automatic logic [NB-1:0] model_levels();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = m_stable[i];
        return v;
    endfunction

    // One clock edge of the reference model, from pre-edge state and inputs
    task automatic model_step();
        bit  rise[NB];
        bit  fall[NB];
        bit  pp_n[NB];
        bit  pr_n[NB];
        int  sel  = -1;
        bit  selp = 1'b0;
        bit  hit  = 1'b0;
        bit  push;
        bit  pop;
        ev_t e;
        pop = (m_q.size() > 0) && evt_ready;
        for (int i = 0; i < NB; i++) begin
            if (sel < 0 && (m_pp[i] || m_pr[i])) begin
                sel  = i;
                selp = m_pp[i];
            end
        end
        push = (sel >= 0) && (m_q.size() < FD);
        for (int i = 0; i < NB; i++) begin
            rise[i] = m_stable[i] && !m_prev[i];
            fall[i] = REL_EN && !m_stable[i] && m_prev[i];
            if ((rise[i] && m_pp[i]) || (fall[i] && m_pr[i])) hit = 1'b1;
            pp_n[i] = (m_pp[i] && !(push && sel == i && selp)) || rise[i];
            pr_n[i] = (m_pr[i] && !(push && sel == i && !selp)) || fall[i];
            if (flush) begin
                pp_n[i] = 0;
                pr_n[i] = 0;
            end
        end
        m_pp = pp_n;
        m_pr = pr_n;
        if (hit) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                e.b = sel[2:0];
                e.p = selp;
                m_q.push_back(e);
            end
        end
        if (m_q.size() > 0) m_head = m_q[0];
        for (int i = 0; i < NB; i++) begin
            m_prev[i] = m_stable[i];
            if (m_s[i] != m_stable[i]) begin
                if (m_cnt[i] == DC - 1) begin
                    m_stable[i] = !m_stable[i];
                    m_cnt[i]    = 0;
                end else begin
                    m_cnt[i]++;
                end
            end else begin
                m_cnt[i] = 0;
            end
            m_s[i]  = m_s1[i];
            m_s1[i] = btn_raw[i];
        end
    endtask

    task automatic compare_all();
        check("btn_stable", btn_stable, model_levels());
        check("evt_valid", evt_valid, m_q.size() > 0);
        check("evt_btn", evt_btn, m_head.b);
        check("evt_press", evt_press, REL_EN ? m_head.p : 1'b1);
        check("evt_overflow", evt_overflow, m_ovf);
    endtask

    task automatic step();
        ev_t e;
        if (evt_valid && evt_ready) begin
            e.b = evt_btn;
            e.p = evt_press;
            obs_q.push_back(e);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear at once
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_btn_stable", btn_stable, '0);
        check("rst_evt_valid", evt_valid, 1'b0);
        check("rst_evt_btn", evt_btn, 3'd0);
        check("rst_evt_press", evt_press, REL_EN ? 1'b0 : 1'b1);
        check("rst_evt_overflow", evt_overflow, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_obs(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            check(tag, (k < obs_q.size()) ? obs_q[k] : 4'hF, exp_q[k]);
        end
    endtask

    function automatic ev_t mk(input int b, input bit p);
        ev_t e;
        e.b = b[2:0];
        e.p = p;
        return e;
    endfunction

    logic [NB-1:0] tgt;
    logic [NB-1:0] glitch;
    int            rdy_pct;

    initial begin
        model_reset();
        do_reset();

        // Clean press on button 2
        evt_ready  = 1'b0;
        btn_raw[2] = 1'b1;
        run(5);
        check("press_not_yet_stable", btn_stable[2], 1'b0);
        step();
        check("press_stable", btn_stable[2], 1'b1);
        step();
        check("press_not_yet_valid", evt_valid, 1'b0);
        step();
        check("press_valid", evt_valid, 1'b1);
        check("press_btn", evt_btn, 3'd2);
        check("press_type", evt_press, 1'b1);
        evt_ready = 1'b1;
        step();
        check("press_popped", evt_valid, 1'b0);

        // Bounce on button 0 yields a single press
        obs_q.delete();
        btn_raw[0] = 1'b1; run(3);
        btn_raw[0] = 1'b0; run(1);
        btn_raw[0] = 1'b1; run(10);
        run(6);
        exp_q.delete();
        exp_q.push_back(mk(0, 1'b1));
        check_obs("bounce");

        // Release everything, then three simultaneous presses
        btn_raw = '0;
        run(14);
        obs_q.delete();
        btn_raw = 8'b0010_1010;
        run(14);
        exp_q.delete();
        exp_q.push_back(mk(1, 1'b1));
        exp_q.push_back(mk(3, 1'b1));
        exp_q.push_back(mk(5, 1'b1));
        check_obs("simul_order");

        // Backpressure: more events than FIFO entries
        btn_raw = '0;
        run(14);
        evt_ready = 1'b0;
        btn_raw[2:0] = 3'b111; run(10);
        btn_raw[2:0] = 3'b000; run(10);
        check("bp_no_overflow", evt_overflow, 1'b0);
        check("bp_valid", evt_valid, 1'b1);
        obs_q.delete();
        evt_ready = 1'b1;
        run(14);
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(i, 1'b1));
        if (REL_EN) for (int i = 0; i < 3; i++) exp_q.push_back(mk(i, 1'b0));
        check_obs("bp_drain");

        // Overflow: FIFO full, pending press on 0, then 0 released and re-pressed
        evt_ready = 1'b0;
        btn_raw   = 8'b0001_1110; run(12);
        btn_raw[0] = 1'b1; run(10);
        check("ovf_still_clear", evt_overflow, 1'b0);
        btn_raw[0] = 1'b0; run(8);
        btn_raw[0] = 1'b1; run(8);
        check("ovf_set", evt_overflow, 1'b1);
        ovf_clr = 1'b1; step();
        ovf_clr = 1'b0;
        check("ovf_cleared", evt_overflow, 1'b0);
        btn_raw   = '0;
        evt_ready = 1'b1;
        run(30);

        // Flush with three queued events, then reset mid-stream
        evt_ready = 1'b0;
        btn_raw   = 8'b1110_0000; run(12);
        check("flush_pre_valid", evt_valid, 1'b1);
        flush = 1'b1; step();
        flush = 1'b0;
        check("flush_valid", evt_valid, 1'b0);
        check("flush_levels", btn_stable[7:5], 3'b111);
        btn_raw = 8'b0000_0111; run(9);
        do_reset();
        run(12);

        // Randomised activity
        tgt     = btn_raw;
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) begin
                case ((c / 300) % 3)
                    0:       rdy_pct = 15;
                    1:       rdy_pct = 60;
                    default: rdy_pct = 95;
                endcase
            end
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 39) == 0) tgt[i] = ~tgt[i];
            end
            glitch = '0;
            if ($urandom_range(0, 7) == 0) glitch[$urandom_range(0, NB - 1)] = 1'b1;
            btn_raw   = tgt ^ glitch;
            evt_ready = ($urandom_range(0, 99) < rdy_pct);
            flush     = ($urandom_range(0, 299) == 0);
            ovf_clr   = ($urandom_range(0, 59) == 0);
            if (c == 1500) do_reset();
            step();
        end
        flush   = 1'b0;
        ovf_clr = 1'b0;
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
